// File: rtl/bmem_arbiter_pkg.sv
// Shared widths, types and helpers for the burst-memory arbiter.
// The instruction and data caches both use these definitions.
package bmem_arbiter_pkg;

  localparam int ADDR_WIDTH  = 32;
  localparam int BEAT_WIDTH  = 64;
  localparam int BURST_LEN   = 4;
  localparam int LINE_WIDTH  = BEAT_WIDTH * BURST_LEN;
  localparam int OFFSET_BITS = 5;

  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef logic [BEAT_WIDTH-1:0] beat_t;
  typedef logic [LINE_WIDTH-1:0] line_t;

  typedef enum logic {REQ_I = 1'b0, REQ_D = 1'b1} req_id_t;

  typedef enum logic [1:0] {IDLE, ISSUE, WBURST} issue_state_t;

  function automatic addr_t line_align(input addr_t a);
    return {a[ADDR_WIDTH-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
  endfunction

endpackage

// File: rtl/bmem_arbiter_if.sv
// Burst-memory port bundle: master is the arbiter, slave is the memory.
interface bmem_arbiter_if;
  import bmem_arbiter_pkg::*;

  addr_t bmem_addr;
  logic  bmem_read;
  logic  bmem_write;
  beat_t bmem_wdata;
  logic  bmem_ready;
  addr_t bmem_raddr;
  beat_t bmem_rdata;
  logic  bmem_rvalid;

  modport master (
    output bmem_addr, bmem_read, bmem_write, bmem_wdata,
    input  bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid
  );

  modport slave (
    input  bmem_addr, bmem_read, bmem_write, bmem_wdata,
    output bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid
  );
endinterface

// File: rtl/bmem_read_deser.sv
// Reassembles four returning beats into a cacheline and identifies its owner
// by matching the burst address against the outstanding table on beat 0.
module bmem_read_deser
  import bmem_arbiter_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  logic    rvalid_i,
  input  addr_t   raddr_i,
  input  beat_t   rdata_i,
  input  logic    ost_i_valid_i,
  input  addr_t   ost_i_addr_i,
  input  logic    ost_d_valid_i,
  input  addr_t   ost_d_addr_i,
  output logic    done_o,
  output req_id_t done_id_o,
  output line_t   done_line_o
);

  logic [1:0] cnt_q, cnt_d;
  logic       own_valid_q, own_valid_d;
  req_id_t    own_q, own_d;
  beat_t      asm_q [BURST_LEN-1];

  logic       hit_i, hit_d, cur_valid;
  req_id_t    cur_own;

  assign hit_i = ost_i_valid_i && (ost_i_addr_i == line_align(raddr_i));
  assign hit_d = ost_d_valid_i && (ost_d_addr_i == line_align(raddr_i));

  // Beat 0 decides ownership live; later beats use the latched owner.
  always_comb begin
    cnt_d       = cnt_q;
    own_valid_d = own_valid_q;
    own_d       = own_q;
    cur_valid   = own_valid_q;
    cur_own     = own_q;
    if (cnt_q == 2'd0) begin
      cur_valid = hit_i || hit_d;
      cur_own   = hit_i ? REQ_I : REQ_D;
    end
    if (rvalid_i) begin
      cnt_d = cnt_q + 2'd1;
      if (cnt_q == 2'd0) begin
        own_valid_d = cur_valid;
        own_d       = cur_own;
      end
    end
    done_o      = rvalid_i && (cnt_q == 2'd3) && cur_valid;
    done_id_o   = cur_own;
    done_line_o = {rdata_i, asm_q[2], asm_q[1], asm_q[0]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= 2'd0;
      own_valid_q <= 1'b0;
      own_q       <= REQ_I;
    end else begin
      cnt_q       <= cnt_d;
      own_valid_q <= own_valid_d;
      own_q       <= own_d;
    end
  end

  for (genvar gi = 0; gi < BURST_LEN - 1; gi++) begin : g_asm
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
        asm_q[gi] <= '0;
      else if (rvalid_i && (cnt_q == 2'(gi)))
        asm_q[gi] <= rdata_i;
    end
  end

  always @(posedge clk) begin
    if (rst_n && rvalid_i && (cnt_q == 2'd0))
      assert (hit_i || hit_d)
      else $warning("bmem_read_deser: dropping burst with raddr %h, no outstanding owner", raddr_i);
  end

endmodule

// File: rtl/bmem_arbiter.sv
// Shares one burst-memory port between icache (reads) and dcache (reads and
// writebacks); up to one outstanding transaction per cache.
module bmem_arbiter
  import bmem_arbiter_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  addr_t i_addr,
  input  logic  i_read,
  output line_t i_rdata,
  output logic  i_resp,
  input  addr_t d_addr,
  input  logic  d_read,
  input  logic  d_write,
  input  line_t d_wdata,
  output line_t d_rdata,
  output logic  d_resp,
  bmem_arbiter_if.master bmem
);

  issue_state_t state_q, state_d;
  req_id_t      rr_q, rr_d, gnt_q, gnt_d, gnt;
  logic [1:0]   busy_q, busy_d, ost_valid_q, ost_valid_d;
  addr_t        ost_addr_q [2];
  addr_t        ost_addr_d [2];
  logic [1:0]   wbeat_q, wbeat_d, wbeat_nxt;
  addr_t        bmem_addr_q, bmem_addr_d;
  logic         bmem_read_q, bmem_read_d, bmem_write_q, bmem_write_d;
  beat_t        bmem_wdata_q, bmem_wdata_d;
  line_t        i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
  logic         i_resp_q, i_resp_d, d_resp_q, d_resp_d;

  logic         done;
  req_id_t      done_id;
  line_t        done_line;
  addr_t        a_i, a_d;
  logic         elig_i, elig_d;

  bmem_read_deser u_deser (
    .clk           (clk),
    .rst_n         (rst_n),
    .rvalid_i      (bmem.bmem_rvalid),
    .raddr_i       (bmem.bmem_raddr),
    .rdata_i       (bmem.bmem_rdata),
    .ost_i_valid_i (ost_valid_q[REQ_I]),
    .ost_i_addr_i  (ost_addr_q[REQ_I]),
    .ost_d_valid_i (ost_valid_q[REQ_D]),
    .ost_d_addr_i  (ost_addr_q[REQ_D]),
    .done_o        (done),
    .done_id_o     (done_id),
    .done_line_o   (done_line)
  );

  assign a_i = line_align(i_addr);
  assign a_d = line_align(d_addr);

  // A read of a line the other cache is still waiting on would make the
  // returning raddr ambiguous, so it waits for that entry to clear.
  assign elig_i = i_read && !busy_q[REQ_I]
                  && !(ost_valid_q[REQ_D] && (ost_addr_q[REQ_D] == a_i));
  assign elig_d = (d_read || d_write) && !busy_q[REQ_D]
                  && !(d_read && ost_valid_q[REQ_I] && (ost_addr_q[REQ_I] == a_d));

  assign wbeat_nxt = wbeat_q + 2'd1;

  always_comb begin
    state_d      = state_q;
    rr_d         = rr_q;
    gnt_d        = gnt_q;
    gnt          = REQ_I;
    busy_d       = busy_q;
    ost_valid_d  = ost_valid_q;
    ost_addr_d   = ost_addr_q;
    wbeat_d      = wbeat_q;
    bmem_addr_d  = bmem_addr_q;
    bmem_read_d  = bmem_read_q;
    bmem_write_d = bmem_write_q;
    bmem_wdata_d = bmem_wdata_q;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;
    i_resp_d     = 1'b0;
    d_resp_d     = 1'b0;

    // Busy/outstanding stay set through the resp cycle so a held request
    // is not re-granted; they drop at the end of it.
    if (i_resp_q) begin
      busy_d[REQ_I]      = 1'b0;
      ost_valid_d[REQ_I] = 1'b0;
    end
    if (d_resp_q) begin
      busy_d[REQ_D]      = 1'b0;
      ost_valid_d[REQ_D] = 1'b0;
    end

    if (done) begin
      if (done_id == REQ_I) begin
        i_rdata_d = done_line;
        i_resp_d  = 1'b1;
      end else begin
        d_rdata_d = done_line;
        d_resp_d  = 1'b1;
      end
    end

    unique case (state_q)
      IDLE: begin
        if (elig_i || elig_d) begin
          if (elig_i && elig_d) begin
            gnt  = rr_q;
            rr_d = (rr_q == REQ_I) ? REQ_D : REQ_I;
          end else begin
            gnt  = elig_i ? REQ_I : REQ_D;
          end
          gnt_d       = gnt;
          busy_d[gnt] = 1'b1;
          state_d     = ISSUE;
          if (gnt == REQ_I) begin
            bmem_addr_d = a_i;
            bmem_read_d = 1'b1;
          end else begin
            bmem_addr_d = a_d;
            if (d_write) begin
              bmem_write_d = 1'b1;
              bmem_wdata_d = d_wdata[0 +: BEAT_WIDTH];
            end else begin
              bmem_read_d  = 1'b1;
            end
          end
        end
      end
      ISSUE: begin
        if (bmem.bmem_ready) begin
          if (bmem_read_q) begin
            bmem_read_d        = 1'b0;
            ost_valid_d[gnt_q] = 1'b1;
            ost_addr_d[gnt_q]  = bmem_addr_q;
            state_d            = IDLE;
          end else begin
            wbeat_d      = 2'd1;
            bmem_wdata_d = d_wdata[BEAT_WIDTH +: BEAT_WIDTH];
            state_d      = WBURST;
          end
        end
      end
      WBURST: begin
        if (wbeat_q == 2'd3) begin
          bmem_write_d = 1'b0;
          bmem_wdata_d = '0;
          wbeat_d      = 2'd0;
          d_resp_d     = 1'b1;
          state_d      = IDLE;
        end else begin
          wbeat_d      = wbeat_nxt;
          bmem_wdata_d = d_wdata[wbeat_nxt*BEAT_WIDTH +: BEAT_WIDTH];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      rr_q          <= REQ_D;
      gnt_q         <= REQ_I;
      busy_q        <= '0;
      ost_valid_q   <= '0;
      ost_addr_q[0] <= '0;
      ost_addr_q[1] <= '0;
      wbeat_q       <= 2'd0;
      bmem_addr_q   <= '0;
      bmem_read_q   <= 1'b0;
      bmem_write_q  <= 1'b0;
      bmem_wdata_q  <= '0;
      i_rdata_q     <= '0;
      d_rdata_q     <= '0;
      i_resp_q      <= 1'b0;
      d_resp_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      rr_q          <= rr_d;
      gnt_q         <= gnt_d;
      busy_q        <= busy_d;
      ost_valid_q   <= ost_valid_d;
      ost_addr_q    <= ost_addr_d;
      wbeat_q       <= wbeat_d;
      bmem_addr_q   <= bmem_addr_d;
      bmem_read_q   <= bmem_read_d;
      bmem_write_q  <= bmem_write_d;
      bmem_wdata_q  <= bmem_wdata_d;
      i_rdata_q     <= i_rdata_d;
      d_rdata_q     <= d_rdata_d;
      i_resp_q      <= i_resp_d;
      d_resp_q      <= d_resp_d;
    end
  end

  assign bmem.bmem_addr  = bmem_addr_q;
  assign bmem.bmem_read  = bmem_read_q;
  assign bmem.bmem_write = bmem_write_q;
  assign bmem.bmem_wdata = bmem_wdata_q;
  assign i_rdata         = i_rdata_q;
  assign i_resp          = i_resp_q;
  assign d_rdata         = d_rdata_q;
  assign d_resp          = d_resp_q;

endmodule

// File: tb/tb_bmem_arbiter.sv
// Directed scoreboard bench: stimulus pushes expectations, a negedge monitor
// pops and compares whenever the arbiter presents a resp, issue or write beat.
module tb_bmem_arbiter;
  import bmem_arbiter_pkg::*;

  logic  clk = 1'b0;
  logic  rst_n = 1'b0;
  addr_t i_addr, d_addr;
  logic  i_read, d_read, d_write, i_resp, d_resp;
  line_t d_wdata, i_rdata, d_rdata;

  bmem_arbiter_if bus ();

  bmem_arbiter dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_addr  (i_addr),
    .i_read  (i_read),
    .i_rdata (i_rdata),
    .i_resp  (i_resp),
    .d_addr  (d_addr),
    .d_read  (d_read),
    .d_write (d_write),
    .d_wdata (d_wdata),
    .d_rdata (d_rdata),
    .d_resp  (d_resp),
    .bmem    (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic  is_write;
    line_t data;
  } dexp_t;

  int    tests = 0;
  int    fails = 0;
  int    cyc = 0;
  int    rd_accepts = 0;
  int    wb_cnt = 0;
  int    last_wb_cyc = -10;
  line_t exp_i [$];
  dexp_t exp_d [$];
  addr_t exp_rd [$];
  beat_t exp_wb [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("[TB] ok %s = %h", name, act);
    end
  endtask

  task automatic unexpected(input string name);
    tests++;
    fails++;
    $display("FAIL %s: event seen with nothing expected", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic line_t mk_line(input beat_t b0, input beat_t b1, input beat_t b2, input beat_t b3);
    return {b3, b2, b1, b0};
  endfunction

  // Monitor: every DUT-presented event is checked against the scoreboard.
  always @(negedge clk) begin
    if (!rst_n) begin
      wb_cnt = 0;
    end else begin
      if (i_resp) begin
        if (exp_i.size() == 0) unexpected("i_resp");
        else check("i_rdata", i_rdata, exp_i.pop_front());
      end
      if (d_resp) begin
        if (exp_d.size() == 0) unexpected("d_resp");
        else begin
          dexp_t e;
          e = exp_d.pop_front();
          if (e.is_write) check("d_wr_resp_cycle", cyc, last_wb_cyc + 1);
          else check("d_rdata", d_rdata, e.data);
        end
      end
      if (bus.bmem_read && bus.bmem_ready) begin
        rd_accepts++;
        if (exp_rd.size() == 0) unexpected("rd_issue");
        else check("rd_issue_addr", bus.bmem_addr, exp_rd.pop_front());
      end
      if (bus.bmem_write) begin
        if (exp_wb.size() == 0) unexpected("wr_beat");
        else if (wb_cnt != 0 || bus.bmem_ready) begin
          check("wr_beat", bus.bmem_wdata, exp_wb.pop_front());
          if (wb_cnt == 3) last_wb_cyc = cyc;
          wb_cnt = (wb_cnt + 1) % 4;
        end else begin
          check("wr_beat0_hold", bus.bmem_wdata, exp_wb[0]);
        end
      end
    end
  end

  task automatic do_iread(input addr_t a, input line_t l, output int rcyc);
    int n;
    exp_i.push_back(l);
    i_addr = a;
    i_read = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (!i_resp && n < 200);
    tests++;
    if (!i_resp) begin
      fails++;
      $display("FAIL i_resp_timeout: got no resp after %0d cycles, required one", n);
    end
    rcyc = cyc;
    i_read = 1'b0;
  endtask

  task automatic do_dreq(input logic w, input addr_t a, input line_t wd, input line_t l, output int rcyc);
    int n;
    dexp_t e;
    e.is_write = w;
    e.data = l;
    exp_d.push_back(e);
    d_addr = a;
    d_wdata = wd;
    d_write = w;
    d_read = !w;
    n = 0;
    do begin
      tick();
      n++;
    end while (!d_resp && n < 200);
    tests++;
    if (!d_resp) begin
      fails++;
      $display("FAIL d_resp_timeout: got no resp after %0d cycles, required one", n);
    end
    rcyc = cyc;
    d_read = 1'b0;
    d_write = 1'b0;
  endtask

  task automatic send_burst(input addr_t a, input line_t l);
    for (int k = 0; k < 4; k++) begin
      bus.bmem_rvalid = 1'b1;
      bus.bmem_raddr = a;
      bus.bmem_rdata = l[k*64 +: 64];
      tick();
    end
    bus.bmem_rvalid = 1'b0;
  endtask

  task automatic wait_accepts(input int target);
    int k;
    k = 0;
    while (rd_accepts < target && k < 100) begin
      tick();
      k++;
    end
    tests++;
    if (rd_accepts < target) begin
      fails++;
      $display("FAIL rd_accept_timeout: got %0d accepts, required %0d", rd_accepts, target);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int    ic, dc, base;
    line_t l1, l3i, l3d, l4a, l4b, l6, l7, ls, w2, w5;
    beat_t bt;

    i_addr = '0; i_read = 0; d_addr = '0; d_read = 0; d_write = 0; d_wdata = '0;
    bus.bmem_ready = 0; bus.bmem_raddr = '0; bus.bmem_rdata = '0; bus.bmem_rvalid = 0;

    l1  = mk_line({16{4'h1}}, {16{4'h2}}, {16{4'h3}}, {16{4'h4}});
    l3i = mk_line(64'h0100_0000_0000_0001, 64'h0100_0000_0000_0002, 64'h0100_0000_0000_0003, 64'h0100_0000_0000_0004);
    l3d = mk_line(64'h0200_0000_0000_0001, 64'h0200_0000_0000_0002, 64'h0200_0000_0000_0003, 64'h0200_0000_0000_0004);
    l4a = mk_line(64'h3000_0000_0000_00A1, 64'h3000_0000_0000_00A2, 64'h3000_0000_0000_00A3, 64'h3000_0000_0000_00A4);
    l4b = mk_line(64'h3000_0000_0000_00B1, 64'h3000_0000_0000_00B2, 64'h3000_0000_0000_00B3, 64'h3000_0000_0000_00B4);
    l6  = mk_line(64'h6666_0000_0000_0001, 64'h6666_0000_0000_0002, 64'h6666_0000_0000_0003, 64'h6666_0000_0000_0004);
    l7  = mk_line(64'h7777_0000_0000_0001, 64'h7777_0000_0000_0002, 64'h7777_0000_0000_0003, 64'h7777_0000_0000_0004);
    ls  = mk_line({16{4'hE}}, {16{4'hE}}, {16{4'hE}}, {16{4'hE}});
    w2  = mk_line({16{4'hA}}, {16{4'hB}}, {16{4'hC}}, {16{4'hD}});
    w5  = mk_line(64'h5555_0000_0000_0000, 64'h5555_0000_0000_0001, 64'h5555_0000_0000_0002, 64'h5555_0000_0000_0003);

    // Reset state
    repeat (3) tick();
    check("rst_bmem_read", bus.bmem_read, 0);
    check("rst_bmem_write", bus.bmem_write, 0);
    check("rst_bmem_addr", bus.bmem_addr, 0);
    check("rst_bmem_wdata", bus.bmem_wdata, 0);
    check("rst_i_resp", i_resp, 0);
    check("rst_d_resp", d_resp, 0);
    check("rst_i_rdata", i_rdata, 0);
    check("rst_d_rdata", d_rdata, 0);
    rst_n = 1'b1;
    tick();

    // Single icache read
    bus.bmem_ready = 1'b1;
    exp_rd.push_back(32'h0000_1020);
    fork
      do_iread(32'h0000_1020, l1, ic);
      begin
        tick();
        check("t1_read_rise", bus.bmem_read, 1);
        check("t1_bmem_addr", bus.bmem_addr, 32'h0000_1020);
        tick();
        check("t1_read_one_cycle", bus.bmem_read, 0);
        repeat (2) tick();
        send_burst(32'h0000_1020, l1);
      end
    join
    tick();

    // dcache writeback with ready low for three cycles
    bus.bmem_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      bt = w2[k*64 +: 64];
      exp_wb.push_back(bt);
    end
    fork
      do_dreq(1'b1, 32'h8000_0040, w2, '0, dc);
      begin
        tick();
        check("t2_write_rise", bus.bmem_write, 1);
        check("t2_bmem_addr", bus.bmem_addr, 32'h8000_0040);
        repeat (3) tick();
        bus.bmem_ready = 1'b1;
      end
    join
    tick();

    // Simultaneous reads, pointer at dcache: dcache issues first
    exp_rd.push_back(32'h0000_0200);
    exp_rd.push_back(32'h0000_0100);
    fork
      do_iread(32'h0000_0100, l3i, ic);
      do_dreq(1'b0, 32'h0000_0200, '0, l3d, dc);
      begin
        repeat (6) tick();
        send_burst(32'h0000_0100, l3i);
        send_burst(32'h0000_0200, l3d);
      end
    join
    check("t3_i_resp_before_d_resp", (ic < dc), 1);
    tick();

    // Both caches read the same line: second issue waits for first resp
    base = rd_accepts;
    exp_rd.push_back(32'h0000_0300);
    exp_rd.push_back(32'h0000_0300);
    fork
      do_dreq(1'b0, 32'h0000_0300, '0, l4a, dc);
      begin
        tick();
        do_iread(32'h0000_0300, l4b, ic);
      end
      begin
        repeat (6) tick();
        check("t4_one_issue_blocked", rd_accepts, base + 1);
        send_burst(32'h0000_0300, l4a);
        wait_accepts(base + 2);
        repeat (2) tick();
        send_burst(32'h0000_0300, l4b);
      end
    join
    check("t4_d_before_i", (dc < ic), 1);
    tick();

    // Reset in the middle of a write burst
    exp_wb.push_back(w5[63:0]);
    exp_wb.push_back(w5[127:64]);
    d_addr = 32'h9000_0080;
    d_wdata = w5;
    d_write = 1'b1;
    tick();
    tick();
    #5;
    rst_n = 1'b0;
    d_write = 1'b0;
    #1;
    check("t5_rst_bmem_write", bus.bmem_write, 0);
    check("t5_rst_bmem_wdata", bus.bmem_wdata, 0);
    check("t5_rst_bmem_addr", bus.bmem_addr, 0);
    repeat (2) tick();
    check("t5_rst_d_rdata", d_rdata, 0);
    check("t5_rst_i_rdata", i_rdata, 0);
    rst_n = 1'b1;
    tick();
    send_burst(32'h0000_0500, ls);
    repeat (3) tick();
    exp_rd.push_back(32'h0000_0700);
    fork
      do_iread(32'h0000_0715, l7, ic);
      begin
        repeat (4) tick();
        send_burst(32'h0000_0700, l7);
      end
    join
    tick();

    // Spurious burst while icache outstanding
    exp_rd.push_back(32'h0000_0600);
    fork
      do_iread(32'h0000_0600, l6, ic);
      begin
        repeat (4) tick();
        send_burst(32'hDEAD_0000, ls);
        send_burst(32'h0000_0600, l6);
      end
    join

    repeat (5) tick();
    check("end_i_rdata_hold", i_rdata, l6);
    check("end_exp_i_empty", exp_i.size(), 0);
    check("end_exp_d_empty", exp_d.size(), 0);
    check("end_exp_rd_empty", exp_rd.size(), 0);
    check("end_exp_wb_empty", exp_wb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
